dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the pipeline's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and decodes the RV32I width/sign code carried in `funct3`. It performs the access on an internal word-organised SRAM after a programmable number of wait states, then returns load data or a store acknowledge over a second valid/ready channel. It sits between the EX/MEM stage's memory request and the MEM/WB capture, replacing the single-cycle data memory where multi-cycle latency must be modelled.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits; the array depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 2: number of idle cycles inserted before the array access. Legal range is 0..15.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned; byte/half taken from the low bits.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  load result, already extended; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned or had an illegal code; valid with `rsp_valid`.
- `busy`  out  1  a transaction is in flight (state ≠ IDLE).

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - `req_ready` = (state == IDLE).
  - `rsp_valid` = (state == RESP).
- IDLE: on `req_valid && req_ready`, latch we/funct3/addr/wdata and check legality.
  - Illegal request → RESP with the error flag set. No array access and no wait states.
  - Legal request with WAIT_STATES > 0 → WAIT, with the counter loaded to WAIT_STATES-1.
  - Legal request with WAIT_STATES = 0 → ACCESS.
- WAIT: decrement the counter each cycle; at 0, go to ACCESS.
- ACCESS: one cycle, then RESP.
  - Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
  - Store: byte-lane write-enable from funct3 and addr[1:0]; lanes not written keep their old contents.
  - Load: select the lane, sign- or zero-extend, and register the result into `rsp_rdata`.
- RESP: hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`, then go to IDLE.
- Legality rules:
  - H/HU require addr[0] = 0.
  - W requires addr[1:0] = 0.
  - Loads with funct3 ∈ {011, 110, 111} are illegal.
  - Stores with funct3 > 010 are illegal.
- Lane rules:
  - B/BU use lane addr[1:0].
  - H/HU use bytes {addr[1],0} and {addr[1],1}.
  - SB writes wdata[7:0]; SH writes wdata[15:0].
- Array contents are not reset and power up undefined. The bench preloads the array through hierarchical access.

## Timing
- Reset (rst = 0 at an edge):
  - state = IDLE, counter = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `busy` = 0.
  - `req_ready` = 1 from the cycle after the reset edge.
- Reset mid-transaction aborts it. A store still in WAIT is discarded. A store whose ACCESS edge coincides with rst = 0 must not write.
- Latency for a legal request: `rsp_valid` rises WAIT_STATES+2 cycles after the acceptance edge.
- Latency for an illegal request: `rsp_valid` rises 1 cycle after the acceptance edge.
- `req_ready` is low from the cycle after acceptance until the cycle after the response handshake. Minimum spacing between acceptances is WAIT_STATES+3 cycles with `rsp_ready` held at 1.
- A request presented during the RESP handshake cycle is not accepted; it must be held until IDLE.
- Response backpressure: `rsp_valid`/`rsp_rdata`/`rsp_err` stay constant for any number of cycles with `rsp_ready` = 0.
- Inputs are sampled only at the acceptance edge. Changes to req_* afterwards have no effect.

## Test plan
- Word round-trip (WAIT_STATES = 2): SW 0xDEADBEEF @0x40, then LW @0x40 → `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, `rsp_valid` 4 cycles after each acceptance.
- Byte/half extension: word @0x80 = 0x80F17F01.
  - LB @0x83 → 0xFFFFFF80; LBU @0x83 → 0x00000080.
  - LH @0x82 → 0xFFFF80F1; LHU @0x80 → 0x00007F01.
- Partial store merge: word @0x10 = 0x11223344.
  - SB 0xAA @0x11 → LW @0x10 = 0x1122AA44.
  - SH 0xBEEF @0x12 → LW @0x10 = 0xBEEFAA44.
- Errors:
  - LW @0x42 → `rsp_err` = 1, `rsp_rdata` = 0, `rsp_valid` 1 cycle after acceptance.
  - SH @0x41 → error; word @0x40 unchanged.
  - Load with funct3 = 011 → error.
- Backpressure and ordering: hold `rsp_ready` = 0 for 5 cycles with `req_valid` = 1 for a second request.
  - Response stays stable and `req_ready` stays 0.
  - The second request is accepted the cycle after the first response handshake.
- Reset mid-operation: SW 0x12345678 @0x20 accepted, rst = 0 during WAIT.
  - All outputs are 0, `req_ready` = 1 the next cycle.
  - LW @0x20 returns the preloaded prior value.
  - Repeat with rst = 0 asserted in the ACCESS cycle: same result.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the load/store port.
// Accepts one RV32I load/store per transaction over a valid/ready request
// channel, waits WAIT_STATES cycles, accesses a word-organised SRAM with
// byte-lane enables, and returns extended load data or a store acknowledge
// over a valid/ready response channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. The producer holds valid and its
// payload stable until that edge; ready may depend on state only, never on
// the partner's valid in the same cycle.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // FSM state is kept in a plainly named register so checkers can bind to it.
   state_t state;
   logic [3:0] wait_cnt;

   // Request fields captured at the acceptance edge.
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [31:0]           wdata_q;

   // Word-organised array; no reset, contents undefined at power-up.
   logic [31:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [31:0]           rd_word;
   logic [3:0]            wr_be;
   logic [31:0]           wr_lanes;

   // Address bits above the array are deliberately ignored (addresses wrap).
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

   // Legality of a request: alignment for H/W and the set of defined codes.
   function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      if (we) begin
         case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a == 2'b00);
            default: ok = 1'b0;
         endcase
      end else begin
         case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~a[0];
            3'b010:         ok = (a == 2'b00);
            default:        ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // Byte-lane enables for a store of the given width at the given offset.
   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate right-aligned store data onto every lane it could land on.
   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] v;
      case (f3[1:0])
         2'b00:   v = {4{d[7:0]}};
         2'b01:   v = {2{d[15:0]}};
         default: v = d;
      endcase
      return v;
   endfunction

   // Select the addressed lane(s) of a word and sign/zero-extend to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] v;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  v = {{24{b[7]}}, b};
         3'b100:  v = {24'd0, b};
         3'b001:  v = {{16{h[15]}}, h};
         3'b101:  v = {16'd0, h};
         default: v = w;
      endcase
      return v;
   endfunction

   assign word_idx = addr_q[ADDR_WIDTH+1:2];
   assign rd_word  = mem[word_idx];
   assign wr_be    = byte_en(f3_q, addr_q[1:0]);
   assign wr_lanes = store_lanes(f3_q, wdata_q);

   // Handshake and status flags are pure decodes of the state register.
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   // Transaction FSM: accept, wait, access, then hold the response until taken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         wait_cnt  <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         we_q      <= 1'b0;
         f3_q      <= 3'd0;
         addr_q    <= '0;
         wdata_q   <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr[ADDR_WIDTH+1:0];
                  wdata_q <= req_wdata;
                  if (!req_legal(req_we, req_funct3, req_addr[1:0])) begin
                     // Illegal requests skip the array entirely.
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'd0;
                     state     <= ST_RESP;
                  end else begin
                     rsp_err <= 1'b0;
                     if (WAIT_STATES > 0) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= ST_WAIT;
                     end else begin
                        state <= ST_ACCESS;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= ST_ACCESS;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ACCESS: begin
               rsp_rdata <= we_q ? 32'd0 : load_extract(rd_word, f3_q, addr_q[1:0]);
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Array write port: only in ACCESS for a store, and never on a reset edge.
   always_ff @(posedge clk) begin
      if (rst && (state == ST_ACCESS) && we_q) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (WAIT_STATES = 2,
// ADDR_WIDTH = 10). Expected values are hand-computed constants.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int n_checks;
   int n_fail;

   dmem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after an acceptance edge (+1); counts cycles until rsp_valid.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Drive one request, wait for acceptance and response, complete handshake.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
      int n;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("accept_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      // Scramble request fields after acceptance; they must have no effect.
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      wait_rsp(lat);
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk); #1;
   endtask

   task automatic run(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(we, f3, addr, wdata, rd, er, lat);
      check({tag, "_rdata"}, rd, exp_rdata);
      check({tag, "_err"}, 32'(er), 32'(exp_err));
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
   endtask

   int lat_bp;

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_funct3 = 3'd0;
      req_addr = 32'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // Word round-trip
      run("sw_40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 4);
      run("lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 4);

      // Byte/half extension
      dut.mem[32'h20] = 32'h80F17F01;
      run("lb_83",  1'b0, 3'b000, 32'h83, 32'h0, 32'hFFFFFF80, 1'b0, 4);
      run("lbu_83", 1'b0, 3'b100, 32'h83, 32'h0, 32'h00000080, 1'b0, 4);
      run("lh_82",  1'b0, 3'b001, 32'h82, 32'h0, 32'hFFFF80F1, 1'b0, 4);
      run("lhu_80", 1'b0, 3'b101, 32'h80, 32'h0, 32'h00007F01, 1'b0, 4);
      run("lb_81",  1'b0, 3'b000, 32'h81, 32'h0, 32'h0000007F, 1'b0, 4);
      run("lh_wrap", 1'b0, 3'b001, 32'h1080, 32'h0, 32'h00007F01, 1'b0, 4);

      // Partial store merge
      dut.mem[32'h4] = 32'h11223344;
      run("sb_11",   1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, 32'h0, 1'b0, 4);
      run("lw_10_a", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1122AA44, 1'b0, 4);
      run("sh_12",   1'b1, 3'b001, 32'h12, 32'h1234BEEF, 32'h0, 1'b0, 4);
      run("lw_10_b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEFAA44, 1'b0, 4);

      // Errors
      run("lw_42_err",  1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 1);
      run("sh_41_err",  1'b1, 3'b001, 32'h41, 32'hFFFF, 32'h0, 1'b1, 1);
      run("lw_40_kept", 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 4);
      run("ld011_err",  1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1);
      run("st100_err",  1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 1'b1, 1);
      run("lh_43_err",  1'b0, 3'b001, 32'h43, 32'h0, 32'h0, 1'b1, 1);

      // Backpressure and ordering
      rsp_ready = 1'b0;
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0;
      req_valid = 1'b1;
      check("bp_ready_first", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_addr = 32'h10;  // second request, held valid throughout
      wait_rsp(lat_bp);
      check("bp_lat_first", 32'(lat_bp), 32'd4);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
         check("bp_hold_err", 32'(rsp_err), 32'd0);
         check("bp_hold_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_after_hs_ready", 32'(req_ready), 32'd1);
      check("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("bp_second_busy", 32'(busy), 32'd1);
      check("bp_second_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      req_addr = 32'h44;
      wait_rsp(lat_bp);
      check("bp_lat_second", 32'(lat_bp), 32'd4);
      check("bp_rdata_second", rsp_rdata, 32'hBEEFAA44);
      @(posedge clk); #1;

      // Reset during WAIT discards the store
      dut.mem[32'h8] = 32'hCAFEF00D;
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      check("rst_wait_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rst_wait_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("rst_wait");
      rst = 1'b1;
      run("rst_wait_lw", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 4);

      // Reset on the ACCESS edge blocks the write
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      check("rst_acc_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_acc_busy", 32'(busy), 32'd1);
      check("rst_acc_not_resp", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("rst_acc");
      rst = 1'b1;
      run("rst_acc_lw", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
